uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's UART transmitter. Same frame format: 1 start bit (low), BIT_MAX data bits LSB first, 1 stop bit (high), no parity.
- Sits between the board RX pin and the stage-1 loopback and display logic.
- Synchronises the asynchronous line, validates the start bit, samples each bit at mid-period, checks the stop bit.
- Presents each byte with a one-cycle valid strobe, or flags a framing error.

---
 rtl/uart_rx.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : UART receiver. Frame = 1 start bit (low), BIT_MAX data bits
//             LSB first, 1 stop bit (high), no parity. The asynchronous
//             line is brought into the clk domain through two flops. A
//             falling edge arms the receiver. The start bit is re-checked
//             at mid-bit, each data bit is sampled at mid-bit, and the stop
//             bit is checked at its mid point.
//  Ports    : clk       - system clock
//             rst       - asynchronous, active-low reset
//             rx        - serial line, asynchronous to clk, idles high
//             rx_data   - last correctly framed word, bit0 = first data bit
//             rx_valid  - one-cycle pulse, rx_data updated this cycle
//             frame_err - one-cycle pulse, stop bit sampled low
//             rx_busy   - high while a frame is being received
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
   parameter int BPS_MAX = 5208,   // clk cycles per bit, >= 4
   parameter int BIT_MAX = 8       // data bits per frame, 1..15
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   output logic [BIT_MAX-1:0] rx_data,
   output logic               rx_valid,
   output logic               frame_err,
   output logic               rx_busy
);

   localparam int CNT_W = $clog2(BPS_MAX);
   localparam int BIT_W = $clog2(BIT_MAX + 1);

   localparam logic [CNT_W-1:0] c_mid      = CNT_W'(BPS_MAX / 2 - 1);
   localparam logic [CNT_W-1:0] c_end      = CNT_W'(BPS_MAX - 1);
   localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(BIT_MAX - 1);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_start = 2'd1;
   localparam logic [1:0] c_st_data  = 2'd2;
   localparam logic [1:0] c_st_stop  = 2'd3;

   // Synchroniser and edge detect
   logic r_rx_meta;
   logic r_rx_s;
   logic r_rx_d;
   logic w_fall;

   // FSM and datapath
   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [CNT_W-1:0]   r_bps_cnt;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic [BIT_MAX-1:0] r_shift;
   logic [BIT_MAX-1:0] r_rx_data;
   logic               r_rx_valid;
   logic               r_frame_err;

   logic w_mid;
   logic w_end;
   logic w_busy;
   logic w_shift_en;
   logic w_bit_clr;
   logic w_bit_inc;
   logic w_load;
   logic w_err;

   // ------------------------------------------------------------------------
   // Two-flop synchroniser plus one history flop. All three reset high so a
   // line that is idle at reset release never looks like a falling edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_d    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_rx_d    <= r_rx_s;
      end
   end

   assign w_fall = r_rx_d & ~r_rx_s;
   assign w_mid  = (r_bps_cnt == c_mid);
   assign w_end  = (r_bps_cnt == c_end);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_fall) begin
               w_state_next = c_st_start;
            end
         end
         c_st_start: begin
            // Line back high at mid start bit: treat as a glitch.
            if (w_mid && r_rx_s) begin
               w_state_next = c_st_idle;
            end else if (w_end) begin
               w_state_next = c_st_data;
            end
         end
         c_st_data: begin
            if (w_end && (r_bit_cnt == c_last_bit)) begin
               w_state_next = c_st_stop;
            end
         end
         c_st_stop: begin
            // Leave at mid stop bit so a short stop bit still lets the next
            // start edge be seen.
            if (w_mid) begin
               w_state_next = c_st_idle;
            end
         end
         default: begin
            w_state_next = c_st_idle;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output / control decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_busy     = (r_state != c_st_idle);
      w_shift_en = 1'b0;
      w_bit_clr  = 1'b0;
      w_bit_inc  = 1'b0;
      w_load     = 1'b0;
      w_err      = 1'b0;
      case (r_state)
         c_st_start: begin
            w_bit_clr = w_end;
         end
         c_st_data: begin
            w_shift_en = w_mid;
            if (w_end) begin
               if (r_bit_cnt == c_last_bit) begin
                  w_bit_clr = 1'b1;
               end else begin
                  w_bit_inc = 1'b1;
               end
            end
         end
         c_st_stop: begin
            w_load = w_mid & r_rx_s;
            w_err  = w_mid & ~r_rx_s;
         end
         default: begin
            w_busy = w_busy;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bit timing, bit counter, shift register and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bps_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         // Counter idles at 0 and restarts from 0 on every START entry.
         if ((r_state == c_st_idle) || (w_state_next == c_st_idle) || w_end) begin
            r_bps_cnt <= '0;
         end else begin
            r_bps_cnt <= r_bps_cnt + CNT_W'(1);
         end

         if (w_bit_clr) begin
            r_bit_cnt <= '0;
         end else if (w_bit_inc) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
         end

         if (w_shift_en) begin
            for (int i = 0; i < BIT_MAX; i++) begin
               if (r_bit_cnt == BIT_W'(i)) begin
                  r_shift[i] <= r_rx_s;
               end
            end
         end

         if (w_load) begin
            r_rx_data <= r_shift;
         end

         r_rx_valid  <= w_load;
         r_frame_err <= w_err;
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign rx_busy   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx (BPS_MAX=16, BIT_MAX=8).
//             A line-level reference model predicts every output on every
//             cycle from the sampled rx history; directed scenarios add
//             hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

   localparam int B  = 16;        // clk per bit
   localparam int NB = 8;         // data bits
   localparam int M  = B / 2 - 1; // mid count

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx  = 1'b1;
   logic [NB-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          rx_busy;

   uart_rx #(.BPS_MAX(B), .BIT_MAX(NB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = -1;   // index of the most recent rising edge
   int frame_edge = 0;  // first rising edge that sees a start bit

   // Line value as seen by the receiver's input flop at each rising edge.
   bit hist [0:65535];

   // Reference model state
   bit            m_active = 1'b0;
   int            m_e      = 0;   // cycle index of START entry
   logic [NB-1:0] m_bits   = '0;
   logic [NB-1:0] m_data   = '0;
   bit            e_valid, e_err, e_busy;

   // Observed activity
   int            valid_cnt     = 0;
   int            err_cnt       = 0;
   int            last_valid_cyc = 0;
   bit            busy_seen     = 1'b0;
   logic [NB-1:0] got_q [$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // The receiver sees the line two edges late. A high-then-low pair in that
   // delayed view starts a frame one edge later; every decision edge n of a
   // frame uses the line value at edge n-2. Decisions fall at M+1 edges after
   // START entry (start check) and every B edges thereafter (data, stop).
   task automatic model_step();
      int rel;
      int k;
      bit samp;
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (!rst) begin
         m_active = 1'b0;
         m_data   = '0;
      end else begin
         if (m_active && (cyc > m_e + M)) begin
            rel  = cyc - m_e;
            samp = hist[cyc-2];
            if (rel == M + 1) begin
               if (samp) m_active = 1'b0;
            end else if (((rel - M - 1) % B) == 0) begin
               k = (rel - M - 1) / B;
               if (k <= NB) begin
                  m_bits[k-1] = samp;
               end else begin
                  m_active = 1'b0;
                  if (samp) begin
                     m_data  = m_bits;
                     e_valid = 1'b1;
                  end else begin
                     e_err = 1'b1;
                  end
               end
            end
         end
         if (!m_active && (cyc >= 2) && hist[cyc-2] && !hist[cyc-1]) begin
            m_active = 1'b1;
            m_e      = cyc + 1;
         end
      end
      e_busy = m_active && (cyc >= m_e);
   endtask

   // Per-cycle compare, 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         hist[cyc] = rst ? rx : 1'b1;
         model_step();
         chk("rx_valid",  {31'd0, rx_valid},  {31'd0, e_valid});
         chk("frame_err", {31'd0, frame_err}, {31'd0, e_err});
         chk("rx_busy",   {31'd0, rx_busy},   {31'd0, e_busy});
         chk("rx_data",   {24'd0, rx_data},   {24'd0, m_data});
         if (rx_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            got_q.push_back(rx_data);
         end
         if (frame_err) err_cnt++;
         if (rx_busy) busy_seen = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [NB-1:0] d, input int stop_len, input bit stop_val);
      rx = 1'b0;
      frame_edge = cyc + 1;
      repeat (B) @(negedge clk);
      for (int i = 0; i < NB; i++) begin
         rx = d[i];
         repeat (B) @(negedge clk);
      end
      rx = stop_val;
      repeat (stop_len) @(negedge clk);
   endtask

   // START entry is 2 edges after the first edge seeing the start bit, and
   // rx_valid follows 9*16+8 = 152 edges later: 154 edges in total.
   task automatic send_and_check(input logic [NB-1:0] d, input string tag);
      int v0, e0;
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(d, B, 1'b1);
      idle(4);
      chk({"pulses_", tag},  valid_cnt - v0, 1);
      chk({"errs_", tag},    err_cnt - e0, 0);
      chk({"latency_", tag}, last_valid_cyc - frame_edge, 154);
      chk({"data_", tag},    {24'd0, rx_data}, {24'd0, d});
   endtask

   initial begin
      int v0, e0, r, good, bad;
      logic [NB-1:0] d;

      rst = 1'b0;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Idle line
      idle(500);
      chk("idle_valid_cnt", valid_cnt, 0);
      chk("idle_err_cnt",   err_cnt, 0);
      chk("idle_busy_seen", {31'd0, busy_seen}, 0);
      chk("idle_data",      {24'd0, rx_data}, 0);

      // Single frames
      send_and_check(8'hA5, "A5");
      idle(10);
      send_and_check(8'h00, "00");
      idle(10);
      send_and_check(8'hFF, "FF");
      idle(10);
      send_and_check(8'h01, "01");
      idle(10);

      // Back to back. The synchroniser places the stop sample 8 clk into the
      // stop bit, so 9 clk is the shortest stop bit that still reads high.
      got_q.delete();
      e0 = err_cnt;
      send_frame(8'h3C, 9, 1'b1);
      send_frame(8'hC3, B, 1'b1);
      idle(4);
      chk("b2b_count",  got_q.size(), 2);
      chk("b2b_first",  (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hxxxx_xxxx, 32'h3C);
      chk("b2b_second", (got_q.size() > 1) ? {24'd0, got_q[1]} : 32'hxxxx_xxxx, 32'hC3);
      chk("b2b_errs",   err_cnt - e0, 0);
      idle(10);

      // Start-bit glitch
      busy_seen = 1'b0;
      v0 = valid_cnt;
      e0 = err_cnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      idle(40);
      chk("glitch_busy_seen", {31'd0, busy_seen}, 1);
      chk("glitch_valid",     valid_cnt - v0, 0);
      chk("glitch_err",       err_cnt - e0, 0);
      chk("glitch_busy_end",  {31'd0, rx_busy}, 0);

      // Bad stop bit keeps the previous word
      send_and_check(8'hA5, "A5b");
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(8'h55, B, 1'b0);
      idle(20);
      chk("badstop_err",   err_cnt - e0, 1);
      chk("badstop_valid", valid_cnt - v0, 0);
      chk("badstop_data",  {24'd0, rx_data}, 32'hA5);

      // Break: line held low
      e0 = err_cnt;
      rx = 1'b0;
      repeat (400) @(negedge clk);
      chk("break_err",  err_cnt - e0, 1);
      chk("break_busy", {31'd0, rx_busy}, 0);
      idle(30);
      chk("break_err_after", err_cnt - e0, 1);

      // Reset in the middle of a frame
      v0 = valid_cnt;
      e0 = err_cnt;
      d  = 8'h5A;
      rx = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         repeat (B) @(negedge clk);
      end
      rst = 1'b0;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle(20);
      chk("abort_valid", valid_cnt - v0, 0);
      chk("abort_err",   err_cnt - e0, 0);
      chk("abort_data",  {24'd0, rx_data}, 0);
      send_and_check(8'h96, "96");

      // Randomised traffic
      v0 = valid_cnt;
      e0 = err_cnt;
      good = 0;
      bad  = 0;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         d = NB'($urandom);
         if (r == 0) begin
            rx = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            idle(20);
         end else if (r == 1) begin
            send_frame(d, B, 1'b0);
            bad++;
            idle(20);
         end else begin
            send_frame(d, $urandom_range(9, 20), 1'b1);
            good++;
            idle($urandom_range(0, 20));
         end
      end
      idle(40);
      chk("rand_valid_total", valid_cnt - v0, good);
      chk("rand_err_total",   err_cnt - e0, bad);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
